// File: rtl/psw_pkg.sv
// Shared constants for the PSW register and trace-trap sequencer.
package psw_pkg;

  localparam int unsigned PSW_C         = 0;
  localparam int unsigned PSW_V         = 1;
  localparam int unsigned PSW_Z         = 2;
  localparam int unsigned PSW_N         = 3;
  localparam int unsigned PSW_T         = 4;
  localparam int unsigned PSW_PRI_LSB   = 5;
  localparam int unsigned PSW_PMODE_LSB = 12;
  localparam int unsigned PSW_CMODE_LSB = 14;

  typedef enum logic [1:0] {
    MODE_KERNEL = 2'b00,
    MODE_SUPER  = 2'b01,
    MODE_USER   = 2'b11
  } psw_mode_e;

  localparam logic [12:0] PSW_ADDR = 13'o17776;

  typedef enum logic [1:0] {
    TR_IDLE,
    TR_INHIB,
    TR_PEND
  } trace_state_e;

endpackage

// File: rtl/psw_unit_if.sv
// I/O-page write bus carrying the PSW decoder strobe, address and data.
interface psw_unit_if;
  logic        psw_io_wr;
  logic [12:0] iopage_addr;
  logic        iopage_byte_op;
  logic [15:0] data_in;

  modport master (output psw_io_wr, iopage_addr, iopage_byte_op, data_in);
  modport slave  (input  psw_io_wr, iopage_addr, iopage_byte_op, data_in);
endinterface

// File: rtl/psw_trace_fsm.sv
// T-bit trace sequencer: raises trace_req after an instruction with T set,
// skipping exactly one boundary after RTT.
module psw_trace_fsm
  import psw_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic instr_done,
  input  logic rtt,
  input  logic trace_ack,
  input  logic t_bit,
  output logic trace_req
);

  trace_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= TR_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TR_IDLE: begin
        if (rtt)                     state_d = TR_INHIB;
        else if (instr_done && t_bit) state_d = TR_PEND;
      end
      TR_INHIB: if (instr_done) state_d = TR_IDLE;
      TR_PEND:  if (trace_ack)  state_d = TR_IDLE;
      default:  state_d = TR_IDLE;
    endcase
  end

  assign trace_req = (state_q == TR_PEND);

endmodule

// File: rtl/psw_unit.sv
// PDP-11 processor status word with trace-trap sequencing.
// PSW_PREV_MODE_EN enables the mode bits 15:12 and previous-mode tracking.
module psw_unit
  import psw_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  psw_unit_if.slave         bus,
  input  logic              cc_wr,
  input  logic [3:0]        cc_in,
  input  logic              psw_ld,
  input  logic [15:0]       psw_ld_data,
  input  logic              trap_entry,
  input  logic              rtt,
  input  logic              instr_done,
  input  logic              trace_ack,
  output logic [15:0]       psw,
  output logic [2:0]        ipl,
  output logic              trace_req
);

`ifdef PSW_PREV_MODE_EN
  localparam logic [15:0] STORED_MASK = 16'hF0FF;
  logic unused_bits;
  assign unused_bits = ^{bus.data_in[11:8], psw_ld_data[11:8]};
`else
  localparam logic [15:0] STORED_MASK = 16'h00FF;
  logic unused_bits;
  assign unused_bits = ^{bus.data_in[11:8], psw_ld_data[11:8], trap_entry};
`endif

  logic [15:0] psw_q, psw_d;
  logic        io_hit;

  assign io_hit = bus.psw_io_wr && (bus.iopage_addr[12:1] == PSW_ADDR[12:1]);

  // One source wins per cycle; losers are dropped. Masking last keeps
  // bits 11:8 (and the mode bits when disabled) at zero on every path.
  always_comb begin
    psw_d = psw_q;
    if (psw_ld) begin
      psw_d = psw_ld_data;
`ifdef PSW_PREV_MODE_EN
      if (trap_entry) psw_d[PSW_PMODE_LSB +: 2] = psw_q[PSW_CMODE_LSB +: 2];
`endif
    end else if (io_hit) begin
      if (!bus.iopage_byte_op || !bus.iopage_addr[0]) psw_d[7:0]   = bus.data_in[7:0];
      if (!bus.iopage_byte_op ||  bus.iopage_addr[0]) psw_d[15:12] = bus.data_in[15:12];
      psw_d[PSW_T] = psw_q[PSW_T];
    end else if (cc_wr) begin
      psw_d[PSW_N:PSW_C] = cc_in;
    end
    psw_d = psw_d & STORED_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset) psw_q <= '0;
    else       psw_q <= psw_d;
  end

  assign psw = psw_q;
  assign ipl = psw_q[PSW_PRI_LSB +: 3];

  psw_trace_fsm u_trace (
    .clk        (clk),
    .reset      (reset),
    .instr_done (instr_done),
    .rtt        (rtt),
    .trace_ack  (trace_ack),
    .t_bit      (psw_q[PSW_T]),
    .trace_req  (trace_req)
  );

endmodule

// File: tb/tb_psw_unit.sv
// Bench for psw_unit: directed test-plan checks plus randomized traffic
// compared every cycle against a behavioural PSW/trace model.
module tb_psw_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        cc_wr;
  logic [3:0]  cc_in;
  logic        psw_ld;
  logic [15:0] psw_ld_data;
  logic        trap_entry;
  logic        rtt;
  logic        instr_done;
  logic        trace_ack;
  logic [15:0] psw;
  logic [2:0]  ipl;
  logic        trace_req;

  psw_unit_if bus ();

  psw_unit dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .cc_wr       (cc_wr),
    .cc_in       (cc_in),
    .psw_ld      (psw_ld),
    .psw_ld_data (psw_ld_data),
    .trap_entry  (trap_entry),
    .rtt         (rtt),
    .instr_done  (instr_done),
    .trace_ack   (trace_ack),
    .psw         (psw),
    .ipl         (ipl),
    .trace_req   (trace_req)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

`ifdef PSW_PREV_MODE_EN
  localparam bit MODES = 1'b1;
`else
  localparam bit MODES = 1'b0;
`endif

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %06o expected %06o at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: PSW as a value with lane masks, trace as two flags.
  logic [15:0] m_psw  = '0;
  bit          m_pend = 1'b0;
  bit          m_skip = 1'b0;

  function automatic logic [15:0] keep(input logic [15:0] v);
    return MODES ? (v & 16'hF0FF) : (v & 16'h00FF);
  endfunction

  always @(posedge clk) begin
    logic [15:0] old, lanes;
    old = m_psw;
    if (reset) begin
      m_psw = '0; m_pend = 1'b0; m_skip = 1'b0;
    end else begin
      if (m_pend)               m_pend = !trace_ack;
      else if (m_skip)          m_skip = !instr_done;
      else if (rtt)             m_skip = 1'b1;
      else if (instr_done && old[4]) m_pend = 1'b1;

      if (psw_ld) begin
        if (MODES && trap_entry)
          m_psw = keep({psw_ld_data[15:14], old[15:14], psw_ld_data[11:0]});
        else
          m_psw = keep(psw_ld_data);
      end else if (bus.psw_io_wr && (bus.iopage_addr >> 1) == (13'o17776 >> 1)) begin
        if (!bus.iopage_byte_op)      lanes = 16'hF0EF;
        else if (bus.iopage_addr[0])  lanes = 16'hF000;
        else                          lanes = 16'h00EF;
        m_psw = keep((old & ~lanes) | (bus.data_in & lanes));
      end else if (cc_wr) begin
        m_psw = {old[15:4], cc_in};
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("psw_model", psw, m_psw);
      chk("ipl_model", {13'd0, ipl}, {13'd0, m_psw[7:5]});
      chk("trace_req_model", {15'd0, trace_req}, {15'd0, m_pend});
    end
  end

  task automatic clear_inputs();
    reset = 1'b0; cc_wr = 1'b0; cc_in = '0; psw_ld = 1'b0; psw_ld_data = '0;
    trap_entry = 1'b0; rtt = 1'b0; instr_done = 1'b0; trace_ack = 1'b0;
    bus.psw_io_wr = 1'b0; bus.iopage_addr = '0; bus.iopage_byte_op = 1'b0; bus.data_in = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic io_write(input logic [12:0] a, input logic b, input logic [15:0] d);
    bus.psw_io_wr = 1'b1; bus.iopage_addr = a; bus.iopage_byte_op = b; bus.data_in = d;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk_en = 1'b1;
    chk("reset_psw", psw, 16'o0);
    chk("reset_trace_req", {15'd0, trace_req}, 16'd0);

    io_write(13'o17776, 1'b0, 16'o000344);
    step();
    chk("word_write_psw", psw, 16'o000344);
    chk("word_write_ipl", {13'd0, ipl}, 16'd7);

    io_write(13'o17776, 1'b1, 16'o000017);
    step();
    chk("byte_write_even", psw, 16'o000017);
    io_write(13'o17776, 1'b0, 16'o000017);
    cc_wr = 1'b1; cc_in = 4'b0000;
    step();
    chk("io_beats_cc", psw, 16'o000017);

    io_write(13'o17774, 1'b0, 16'o000340);
    step();
    chk("ignore_17774", psw, 16'o000017);

    psw_ld = 1'b1; psw_ld_data = 16'o140000;
    step();
    psw_ld = 1'b1; psw_ld_data = 16'o000340; trap_entry = 1'b1;
    step();
    chk("trap_entry_load", psw, MODES ? 16'o030340 : 16'o000340);

    psw_ld = 1'b1; psw_ld_data = 16'o000020;
    step();
    chk("t_bit_load", psw, 16'o000020);
    instr_done = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("trace_req_held", {15'd0, trace_req}, 16'd1);
      if (i == 1) instr_done = 1'b1;
      if (i == 2) trace_ack = 1'b1;
      if (i < 2 || i == 2) step();
    end
    chk("trace_req_cleared", {15'd0, trace_req}, 16'd0);

    rtt = 1'b1;
    step();
    instr_done = 1'b1;
    step();
    chk("rtt_inhibit", {15'd0, trace_req}, 16'd0);
    instr_done = 1'b1;
    step();
    chk("trace_after_inhibit", {15'd0, trace_req}, 16'd1);
    trace_ack = 1'b1;
    step();

    io_write(13'o17777, 1'b1, 16'o170000);
    step();
    chk("byte_write_odd", psw, MODES ? 16'o170020 : 16'o000020);
    instr_done = 1'b1;
    step();
    chk("pend_before_reset", {15'd0, trace_req}, 16'd1);
    reset = 1'b1; cc_wr = 1'b1; cc_in = 4'hF;
    step();
    chk("reset_in_pend_psw", psw, 16'o0);
    chk("reset_in_pend_req", {15'd0, trace_req}, 16'd0);

    for (int n = 0; n < 3000; n++) begin
      logic [2:0] k;
      reset       = ($urandom_range(0, 199) == 0);
      psw_ld      = ($urandom_range(0, 9) == 0);
      psw_ld_data = 16'($urandom);
      trap_entry  = 1'($urandom);
      cc_wr       = ($urandom_range(0, 2) == 0);
      cc_in       = 4'($urandom);
      rtt         = ($urandom_range(0, 11) == 0);
      instr_done  = ($urandom_range(0, 3) == 0);
      trace_ack   = ($urandom_range(0, 5) == 0);
      k = 3'($urandom_range(0, 5));
      io_write((k < 3'd4) ? (13'o17774 + 13'(k)) : 13'($urandom),
               1'($urandom), 16'($urandom));
      bus.psw_io_wr = ($urandom_range(0, 2) == 0);
      step();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
